// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: moves the operand one bit per clock under a
// start/done handshake, sharing the Op encoding of the combinational barrel shifter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; Out holds the last result
// ST_SHIFT | shifting one bit per edge, cnt counts the remaining steps
// ST_DONE  | Out just updated; start may be accepted again this cycle
module shifter_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work, work_step;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op;

  always_comb begin
    work_step = work;
    case (op)
      2'b00: work_step = {work[WIDTH-2:0], work[WIDTH-1]};
      2'b01: work_step = {work[WIDTH-2:0], 1'b0};
      2'b10: work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      2'b11: work_step = {1'b0, work[WIDTH-1:1]};
      default: work_step = work;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (Cnt == '0) ? ST_DONE : ST_SHIFT;
        else       state_nxt = ST_IDLE;
      end
      ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      op    <= '0;
      Out   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            work <= In;
            cnt  <= Cnt;
            op   <= Op;
            if (Cnt == '0) Out <= In;
          end
        end
        ST_SHIFT: begin
          work <= work_step;
          cnt  <= cnt - 1'b1;
          // Last step: publish the shifted value as it enters DONE.
          if (cnt == CNT_W'(1)) Out <= work_step;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
